// File: rtl/mult64_pkg.sv
// Shared widths and types for the mult64 pipelined multiplier.
package mult64_pkg;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned CHUNK  = 16;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned NPP    = NCHUNK * NCHUNK;

  typedef logic [WIDTH-1:0]   operand_t;
  typedef logic [2*WIDTH-1:0] product_t;
  typedef logic [2*CHUNK-1:0] pp_t;

endpackage

// File: rtl/mult64_mult16x16.sv
// Unsigned combinational CHUNK x CHUNK multiplier producing one partial product.
module mult16x16
  import mult64_pkg::*;
(
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output pp_t              prod_c
);

  // Both operands are widened first so the product is not truncated.
  assign prod_c = pp_t'(a) * pp_t'(b);

endmodule

// File: rtl/mult64.sv
// Two-stage pipelined 64x64 -> 128-bit multiplier.
// Stage 1 registers the 16 chunk partial products; stage 2 sums them into mult.
// Optional macro MULT64_SIGNED_EN adds the tc port for two's-complement operands.
module mult64
  import mult64_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT64_SIGNED_EN
  input  logic               tc,
`endif
  output logic               out_valid,
  output logic [2*WIDTH-1:0] mult
);

  pp_t      pp_c [NPP];
  pp_t      pp_q [NPP];
  logic     v1;
  product_t sum_c;

`ifdef MULT64_SIGNED_EN
  // Sign correction: the signed product equals the unsigned product minus
  // (a<0 ? b : 0)<<WIDTH minus (b<0 ? a : 0)<<WIDTH, modulo 2^(2*WIDTH).
  logic [WIDTH:0] corr_c;
  logic [WIDTH:0] corr_q;

  // Sum of the operands that need subtracting, computed alongside the partial products.
  always_comb begin
    corr_c = '0;
    if (tc && a[WIDTH-1]) corr_c = corr_c + (WIDTH+1)'(b);
    if (tc && b[WIDTH-1]) corr_c = corr_c + (WIDTH+1)'(a);
  end
`endif

  // Partial-product array: slice i of a times slice j of b.
  for (genvar i = 0; i < NCHUNK; i++) begin : g_i
    for (genvar j = 0; j < NCHUNK; j++) begin : g_j
      mult16x16 u_mul (
        .a      (a[i*CHUNK +: CHUNK]),
        .b      (b[j*CHUNK +: CHUNK]),
        .prod_c (pp_c[i*NCHUNK + j])
      );
    end
  end

  // Stage 1: capture partial products when the input is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int unsigned k = 0; k < NPP; k++) pp_q[k] <= '0;
`ifdef MULT64_SIGNED_EN
      corr_q <= '0;
`endif
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        for (int unsigned k = 0; k < NPP; k++) pp_q[k] <= pp_c[k];
`ifdef MULT64_SIGNED_EN
        corr_q <= corr_c;
`endif
      end
    end
  end

  // Stage 2 adder tree: align each partial product by its chunk weight.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      for (int unsigned j = 0; j < NCHUNK; j++) begin
        sum_c = sum_c + (product_t'(pp_q[i*NCHUNK + j]) << (CHUNK*(i+j)));
      end
    end
`ifdef MULT64_SIGNED_EN
    sum_c = sum_c - (product_t'(corr_q) << WIDTH);
`endif
  end

  // Stage 2: register the product; mult holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      mult      <= '0;
    end else begin
      out_valid <= v1;
      if (v1) mult <= sum_c;
    end
  end

endmodule

// File: tb/tb_mult64.sv
// Self-checking bench for mult64: directed vectors plus a random sweep against
// a native 128-bit reference. Covers MULT64_SIGNED_EN when defined.
module tb_mult64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         tc;
  logic         out_valid;
  logic [127:0] mult;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference pipeline state
  logic         m_v1;
  logic [127:0] m_p1;
  logic         m_ov;
  logic [127:0] m_mult;

  mult64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef MULT64_SIGNED_EN
    .tc        (tc),
`endif
    .out_valid (out_valid),
    .mult      (mult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%032h expected 0x%032h", tag, got, exp);
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y, input logic t);
    logic signed [127:0] sx;
    logic signed [127:0] sy;
    logic [127:0]        ux;
    logic [127:0]        uy;
    if (t) begin
      sx = $signed({{64{x[63]}}, x});
      sy = $signed({{64{y[63]}}, y});
      return 128'(sx * sy);
    end
    ux = {64'd0, x};
    uy = {64'd0, y};
    return ux * uy;
  endfunction

  // One clock: drive inputs, step the reference at the edge, then compare.
  task automatic cyc(input logic v, input logic [63:0] av, input logic [63:0] bv, input logic t);
    in_valid = v;
    a        = av;
    b        = bv;
    tc       = t;
    @(posedge clk);
    if (rst) begin
      m_v1 = 1'b0; m_p1 = '0; m_ov = 1'b0; m_mult = '0;
    end else begin
      m_ov = m_v1;
      if (m_v1) m_mult = m_p1;
      m_v1 = v;
      if (v) m_p1 = ref_mul(av, bv, t);
    end
    #1;
    check("model_valid", 128'(out_valid), 128'(m_ov));
    check("model_mult", mult, m_mult);
  endtask

  task automatic idle();
    cyc(1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; tc = 1'b0;
    m_v1 = 1'b0; m_p1 = '0; m_ov = 1'b0; m_mult = '0;

    // Reset then idle
    idle();
    idle();
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_mult", mult, 128'd0);
    rst = 1'b0;
    idle();
    check("idle_valid", 128'(out_valid), 128'd0);
    check("idle_mult", mult, 128'd0);

    // Back-to-back basic products; each emerges one call after its issue call
    cyc(1'b1, 64'd0, 64'd100, 1'b0);
    cyc(1'b1, 64'd1, 64'd121241241, 1'b0);
    check("zero_valid", 128'(out_valid), 128'd1);
    check("zero_mult", mult, 128'd0);
    cyc(1'b1, 64'd264809178, 64'd249197382, 1'b0);
    check("one_valid", 128'(out_valid), 128'd1);
    check("one_mult", mult, 128'd121241241);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("mid_valid", 128'(out_valid), 128'd1);
    check("mid_mult", mult, 128'd65989753887171996);
    cyc(1'b1, 64'h8000_0000_0000_0000, 64'd2, 1'b0);
    check("max_mult", mult, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
    idle();
    check("carry_mult", mult, 128'h1_0000_0000_0000_0000);
    idle();
    check("drain_valid", 128'(out_valid), 128'd0);
    check("drain_hold", mult, 128'h1_0000_0000_0000_0000);

    // Bubble: valid, invalid, valid
    cyc(1'b1, 64'd3, 64'd5, 1'b0);
    cyc(1'b0, 64'd9, 64'd9, 1'b0);
    check("bub0_valid", 128'(out_valid), 128'd1);
    check("bub0_mult", mult, 128'd15);
    cyc(1'b1, 64'd4, 64'd4, 1'b0);
    check("bub1_valid", 128'(out_valid), 128'd0);
    check("bub1_hold", mult, 128'd15);
    idle();
    check("bub2_valid", 128'(out_valid), 128'd1);
    check("bub2_mult", mult, 128'd16);

    // Reset mid-stream flushes in-flight pairs
    cyc(1'b1, 64'd11, 64'd13, 1'b0);
    cyc(1'b1, 64'd17, 64'd19, 1'b0);
    rst = 1'b1;
    idle();
    check("flush_valid", 128'(out_valid), 128'd0);
    check("flush_mult", mult, 128'd0);
    rst = 1'b0;
    cyc(1'b1, 64'd7, 64'd6, 1'b0);
    check("post_rst_valid", 128'(out_valid), 128'd0);
    check("post_rst_mult", mult, 128'd0);
    idle();
    check("post_rst_res_v", 128'(out_valid), 128'd1);
    check("post_rst_res", mult, 128'd42);

`ifdef MULT64_SIGNED_EN
    // Two's-complement products
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1);
    check("s_m1xm1", mult, 128'd1);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("s_m2x3", mult, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFA);
    idle();
    check("s_tc0_max", mult, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
`endif

    // Random regression with occasional bubbles
    for (int n = 0; n < 10000; n++) begin
      logic        rv;
      logic        rt;
      logic [63:0] ra;
      logic [63:0] rb;
      rv = ($urandom_range(0, 7) != 0);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rt = 1'b0;
`ifdef MULT64_SIGNED_EN
      rt = 1'($urandom_range(0, 1));
`endif
      cyc(rv, ra, rb, rt);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
